// File: rtl/arf_seq_ctrl.sv
// Command sequencer for the 8-bit address register file (PC, AR, SP).
// Turns single-cycle commands into cycle-accurate ARF control and memory strobes.
module arf_seq_ctrl #(
    parameter int STACK_DEPTH = 16,
    parameter int DEPTH_W     = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       done,
    output logic       err,
    output logic [7:0] arf_i,
    output logic [1:0] arf_funsel,
    output logic [2:0] arf_rsel,
    output logic [1:0] arf_outasel,
    output logic [1:0] arf_outbsel,
    output logic       mem_re,
    output logic       mem_we
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DEC  = 2'd1,
        ST_SEL  = 2'd2,
        ST_ACC  = 2'd3
    } state_t;

    localparam logic [2:0] OP_FETCH  = 3'd0;
    localparam logic [2:0] OP_PUSH   = 3'd1;
    localparam logic [2:0] OP_POP    = 3'd2;
    localparam logic [2:0] OP_LDPC   = 3'd3;
    localparam logic [2:0] OP_LDSP   = 3'd4;
    localparam logic [2:0] OP_LDAR   = 3'd5;
    localparam logic [2:0] OP_CLRALL = 3'd6;
    localparam logic [2:0] OP_NOP    = 3'd7;

    localparam logic [1:0] FS_CLR = 2'b00;
    localparam logic [1:0] FS_LD  = 2'b01;
    localparam logic [1:0] FS_INC = 2'b10;
    localparam logic [1:0] FS_DEC = 2'b11;

    localparam logic [1:0] OA_SP = 2'b01;
    localparam logic [1:0] OA_PC = 2'b11;

    localparam logic [DEPTH_W-1:0] DEPTH_MAX  = DEPTH_W'(STACK_DEPTH);
    localparam logic [DEPTH_W-1:0] DEPTH_ZERO = {DEPTH_W{1'b0}};
    localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [7:0]         i_q, i_d;
    logic [1:0]         funsel_q, funsel_d;
    logic [2:0]         rsel_q, rsel_d;
    logic [1:0]         outasel_q, outasel_d;
    logic               re_q, re_d;
    logic               we_q, we_d;

    // Next-state and next-output decode; every output describes the cycle after the edge.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        depth_d   = depth_q;
        ready_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        i_d       = 8'h00;
        funsel_d  = FS_CLR;
        rsel_d    = 3'b000;
        outasel_d = OA_PC;
        re_d      = 1'b0;
        we_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    op_d = cmd_op;
                    case (cmd_op)
                        OP_FETCH: begin
                            state_d = ST_SEL;
                        end
                        OP_PUSH: begin
                            if (depth_q == DEPTH_MAX) begin
                                state_d = ST_ACC;
                                done_d  = 1'b1;
                                err_d   = 1'b1;
                            end else begin
                                state_d  = ST_DEC;
                                funsel_d = FS_DEC;
                                rsel_d   = 3'b001;
                            end
                        end
                        OP_POP: begin
                            if (depth_q == DEPTH_ZERO) begin
                                state_d = ST_ACC;
                                done_d  = 1'b1;
                                err_d   = 1'b1;
                            end else begin
                                state_d   = ST_SEL;
                                outasel_d = OA_SP;
                            end
                        end
                        OP_LDPC: begin
                            state_d  = ST_ACC;
                            funsel_d = FS_LD;
                            rsel_d   = 3'b001;
                            i_d      = cmd_data;
                            done_d   = 1'b1;
                        end
                        OP_LDAR: begin
                            state_d  = ST_ACC;
                            funsel_d = FS_LD;
                            rsel_d   = 3'b010;
                            i_d      = cmd_data;
                            done_d   = 1'b1;
                        end
                        OP_LDSP: begin
                            state_d  = ST_ACC;
                            funsel_d = FS_LD;
                            rsel_d   = 3'b100;
                            i_d      = cmd_data;
                            depth_d  = DEPTH_ZERO;
                            done_d   = 1'b1;
                        end
                        OP_CLRALL: begin
                            state_d = ST_ACC;
                            rsel_d  = 3'b111;
                            depth_d = DEPTH_ZERO;
                            done_d  = 1'b1;
                        end
                        default: begin
                            state_d = ST_ACC;
                            done_d  = 1'b1;
                        end
                    endcase
                end else begin
                    ready_d = 1'b1;
                end
            end
            ST_DEC: begin
                // SP has been decremented; select it so OutA carries the new value next cycle.
                state_d   = ST_SEL;
                outasel_d = OA_SP;
            end
            ST_SEL: begin
                state_d = ST_ACC;
                done_d  = 1'b1;
                if (op_q == OP_PUSH) begin
                    outasel_d = OA_SP;
                    we_d      = 1'b1;
                    depth_d   = depth_q + DEPTH_ONE;
                end else if (op_q == OP_POP) begin
                    outasel_d = OA_SP;
                    re_d      = 1'b1;
                    funsel_d  = FS_INC;
                    rsel_d    = 3'b001;
                    depth_d   = depth_q - DEPTH_ONE;
                end else begin
                    re_d     = 1'b1;
                    funsel_d = FS_INC;
                    rsel_d   = 3'b100;
                end
            end
            ST_ACC: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State, depth and registered outputs; reset restores IDLE defaults without touching the ARF.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_NOP;
            depth_q   <= DEPTH_ZERO;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            i_q       <= 8'h00;
            funsel_q  <= FS_CLR;
            rsel_q    <= 3'b000;
            outasel_q <= OA_PC;
            re_q      <= 1'b0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            depth_q   <= depth_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            err_q     <= err_d;
            i_q       <= i_d;
            funsel_q  <= funsel_d;
            rsel_q    <= rsel_d;
            outasel_q <= outasel_d;
            re_q      <= re_d;
            we_q      <= we_d;
        end
    end

    assign cmd_ready   = ready_q;
    assign done        = done_q;
    assign err         = err_q;
    assign arf_i       = i_q;
    assign arf_funsel  = funsel_q;
    assign arf_rsel    = rsel_q;
    assign arf_outasel = outasel_q;
    assign arf_outbsel = 2'b00;
    assign mem_re      = re_q;
    assign mem_we      = we_q;

endmodule

// File: tb/tb_arf_seq_ctrl.sv
// Self-checking bench for arf_seq_ctrl: an ARF model driven by the DUT controls plus a
// command-level reference model of PC/AR/SP, stack depth, latency and memory addresses.
module tb_arf_seq_ctrl;

    localparam logic [2:0] OP_FETCH  = 3'd0;
    localparam logic [2:0] OP_PUSH   = 3'd1;
    localparam logic [2:0] OP_POP    = 3'd2;
    localparam logic [2:0] OP_LDPC   = 3'd3;
    localparam logic [2:0] OP_LDSP   = 3'd4;
    localparam logic [2:0] OP_LDAR   = 3'd5;
    localparam logic [2:0] OP_CLRALL = 3'd6;
    localparam logic [2:0] OP_NOP    = 3'd7;
    localparam int         SDEPTH    = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op = 3'd7;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready, done, err, mem_re, mem_we;
    logic [7:0] arf_i;
    logic [1:0] arf_funsel, arf_outasel, arf_outbsel;
    logic [2:0] arf_rsel;

    int checks = 0;
    int errors = 0;

    // ARF model fed by the DUT's control outputs (OutA registered, sampled pre-update)
    logic [7:0] pc_m = 8'h00, ar_m = 8'h00, sp_m = 8'h00, outa_m = 8'h00;

    // Command-level expectations
    logic [7:0] pc_e = 8'h00, ar_e = 8'h00, sp_e = 8'h00;
    int         depth_e = 0;

    arf_seq_ctrl #(.STACK_DEPTH(SDEPTH), .DEPTH_W(5)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .done(done), .err(err), .arf_i(arf_i), .arf_funsel(arf_funsel),
        .arf_rsel(arf_rsel), .arf_outasel(arf_outasel), .arf_outbsel(arf_outbsel),
        .mem_re(mem_re), .mem_we(mem_we)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        case (arf_outasel)
            2'b00:   outa_m <= ar_m;
            2'b01:   outa_m <= sp_m;
            default: outa_m <= pc_m;
        endcase
        case (arf_funsel)
            2'b00: begin
                if (arf_rsel[0]) pc_m <= 8'h00;
                if (arf_rsel[1]) ar_m <= 8'h00;
                if (arf_rsel[2]) sp_m <= 8'h00;
            end
            2'b01: begin
                if (arf_rsel[0]) pc_m <= arf_i;
                if (arf_rsel[1]) ar_m <= arf_i;
                if (arf_rsel[2]) sp_m <= arf_i;
            end
            2'b10: begin
                if (arf_rsel[2]) pc_m <= pc_m + 8'd1;
                if (arf_rsel[1]) ar_m <= ar_m + 8'd1;
                if (arf_rsel[0]) sp_m <= sp_m + 8'd1;
            end
            default: begin
                if (arf_rsel[2]) pc_m <= pc_m - 8'd1;
                if (arf_rsel[1]) ar_m <= ar_m - 8'd1;
                if (arf_rsel[0]) sp_m <= sp_m - 8'd1;
            end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command and check its whole timeline against the reference model.
    task automatic run_cmd(input logic [2:0] op, input logic [7:0] data);
        int         lat;
        int         cyc;
        int         n;
        logic       e_err, e_re, e_we, has_addr, is_ld;
        logic [7:0] addr;
        lat = 1; e_err = 1'b0; e_re = 1'b0; e_we = 1'b0; has_addr = 1'b0; is_ld = 1'b0; addr = 8'h00;
        case (op)
            OP_FETCH: begin lat = 2; e_re = 1'b1; has_addr = 1'b1; addr = pc_e; pc_e = pc_e + 8'd1; end
            OP_PUSH: begin
                if (depth_e == SDEPTH) e_err = 1'b1;
                else begin lat = 3; sp_e = sp_e - 8'd1; addr = sp_e; e_we = 1'b1; has_addr = 1'b1; depth_e++; end
            end
            OP_POP: begin
                if (depth_e == 0) e_err = 1'b1;
                else begin lat = 2; addr = sp_e; sp_e = sp_e + 8'd1; e_re = 1'b1; has_addr = 1'b1; depth_e--; end
            end
            OP_LDPC:   begin pc_e = data; is_ld = 1'b1; end
            OP_LDAR:   begin ar_e = data; is_ld = 1'b1; end
            OP_LDSP:   begin sp_e = data; depth_e = 0; is_ld = 1'b1; end
            OP_CLRALL: begin pc_e = 8'h00; ar_e = 8'h00; sp_e = 8'h00; depth_e = 0; end
            default:   begin end
        endcase
        n = 0;
        while (cmd_ready !== 1'b1 && n < 10) begin tick(); n++; end
        chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
        tick();
        cmd_valid = 1'($urandom_range(0, 1)); cmd_op = 3'($urandom); cmd_data = 8'($urandom);
        cyc = 1;
        while (done !== 1'b1 && cyc < 6) begin
            chk("busy_ready_low", 32'(cmd_ready), 32'd0);
            chk("busy_no_strobe", 32'({mem_re, mem_we}), 32'd0);
            tick();
            cyc++;
        end
        cmd_valid = 1'b0;
        chk("done_seen", 32'(done), 32'd1);
        chk("latency", 32'(cyc), 32'(lat));
        chk("done_ready_low", 32'(cmd_ready), 32'd0);
        chk("err", 32'(err), 32'(e_err));
        chk("mem_re", 32'(mem_re), 32'(e_re));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("outbsel", 32'(arf_outbsel), 32'd0);
        if (has_addr) chk("mem_addr", 32'(outa_m), 32'(addr));
        if (e_err) chk("err_rsel", 32'(arf_rsel), 32'd0);
        if (is_ld) chk("load_data", 32'({arf_funsel, arf_i}), 32'({2'b01, data}));
        tick();
        chk("done_pulse_end", 32'({done, err}), 32'd0);
        chk("ready_after", 32'(cmd_ready), 32'd1);
        chk("regs_after", 32'({pc_m, ar_m, sp_m}), 32'({pc_e, ar_e, sp_e}));
    endtask

    initial begin
        logic [2:0] op;
        int         r;
        cmd_valid = 1'b1;
        cmd_op = OP_PUSH;
        reset = 1'b1;
        tick(); tick();
        chk("rst_outputs", 32'({cmd_ready, done, err, mem_re, mem_we}), 32'b10000);
        chk("rst_arf_ctrl", 32'({arf_funsel, arf_rsel, arf_outasel, arf_outbsel, arf_i}),
            32'({2'b00, 3'b000, 2'b11, 2'b00, 8'h00}));
        reset = 1'b0;
        cmd_valid = 1'b0;
        tick();
        chk("rst_no_accept", 32'({cmd_ready, done}), 32'b10);

        // Fetch, push/pop, underflow, overflow
        run_cmd(OP_LDPC, 8'h40);
        run_cmd(OP_FETCH, 8'h00);
        run_cmd(OP_LDSP, 8'h80);
        run_cmd(OP_PUSH, 8'h00);
        run_cmd(OP_POP, 8'h00);
        run_cmd(OP_POP, 8'h00);
        for (int k = 0; k < SDEPTH + 1; k++) run_cmd(OP_PUSH, 8'h00);
        run_cmd(OP_LDAR, 8'h22);
        run_cmd(OP_CLRALL, 8'h00);
        run_cmd(OP_NOP, 8'h00);

        // Reset during PUSH T2
        run_cmd(OP_LDSP, 8'h80);
        cmd_valid = 1'b1; cmd_op = OP_PUSH;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("push_t2_sel", 32'({arf_outasel, mem_we}), 32'b010);
        reset = 1'b1; cmd_valid = 1'b1; cmd_op = OP_NOP;
        tick();
        chk("midrst_idle", 32'({cmd_ready, done, mem_we, mem_re}), 32'b1000);
        chk("midrst_ctrl", 32'({arf_funsel, arf_rsel, arf_outasel}), 32'({2'b00, 3'b000, 2'b11}));
        tick();
        reset = 1'b0; cmd_valid = 1'b0;
        tick();
        chk("midrst_no_accept", 32'({cmd_ready, done, mem_we}), 32'b100);
        chk("midrst_sp", 32'(sp_m), 32'h7F);
        sp_e = 8'h7F; depth_e = 0;
        run_cmd(OP_POP, 8'h00);

        // Randomized command stream
        for (int k = 0; k < 250; k++) begin
            r = int'($urandom_range(0, 11));
            case (r)
                0, 1, 2, 3: op = OP_PUSH;
                4, 5:       op = OP_POP;
                6, 7:       op = OP_FETCH;
                8:          op = ($urandom_range(0, 1) == 0) ? OP_LDPC : OP_LDAR;
                9:          op = OP_NOP;
                10:         op = ($urandom_range(0, 3) == 0) ? OP_CLRALL : OP_POP;
                default:    op = ($urandom_range(0, 3) == 0) ? OP_LDSP : OP_FETCH;
            endcase
            run_cmd(op, 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arf_seq_ctrl.md
Name: arf_seq_ctrl

Overview:
- Command sequencer for the 8-bit Address Register File (PC, AR, SP). It turns single-cycle command requests into cycle-accurate ARF control (FunSel, RSel, OutASel, I) plus memory strobes.
- Supported operations: instruction fetch, stack push/pop, register loads and clear.
- Sits between the instruction control unit and the ARF/memory address path.
- Tracks stack depth and rejects push on overflow and pop on underflow.

Parameters:
- STACK_DEPTH, 16, maximum entries; push is rejected when depth == STACK_DEPTH.
- DEPTH_W, 5, width of the internal depth counter; must hold STACK_DEPTH.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_op  in  3  0 FETCH, 1 PUSH, 2 POP, 3 LDPC, 4 LDSP, 5 LDAR, 6 CLRALL, 7 NOP
- cmd_data  in  8  load value for LDPC/LDSP/LDAR
- cmd_ready  out  1  high only in IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with done on a rejected PUSH/POP
- arf_i  out  8  ARF load data
- arf_funsel  out  2  00 clear, 01 load, 10 inc, 11 dec
- arf_rsel  out  3  ARF register select
- arf_outasel  out  2  00 AR, 01 SP, 10 PCPast, 11 PC
- arf_outbsel  out  2  constant 2'b00 (AR)
- mem_re  out  1  memory read strobe; address = ARF OutA
- mem_we  out  1  memory write strobe; address = ARF OutA

Behaviour:
- RSel bit map:
  - Clear/load: bit0 PC, bit1 AR, bit2 SP.
  - Inc/dec: bit2 PC, bit1 AR, bit0 SP.
  - The block encodes each operation per this map.
- ARF OutA is registered and samples pre-update register values. An address is therefore valid on OutA one cycle after arf_outasel is driven, and the block sequences around this.
- Default outputs (reset and IDLE):
  - arf_funsel=00, arf_rsel=000 (no ARF effect), arf_outasel=11, arf_i=0.
  - done=err=mem_re=mem_we=0, depth=0.
- States: IDLE, DEC, SEL, ACC.
- Acceptance: a command is accepted on a clk edge with cmd_valid && cmd_ready. cmd_op and cmd_data are latched; cmd_ready drops the next cycle. T1 is the first cycle after acceptance.
- FETCH:
  - T1 SEL: outasel=11.
  - T2 ACC: outasel=11, mem_re=1, funsel=10, rsel=100 (PC++), done=1.
  - Next state IDLE.
- PUSH (pre-decrement):
  - T1 DEC: funsel=11, rsel=001 (SP--).
  - T2 SEL: outasel=01.
  - T3 ACC: outasel=01, mem_we=1, done=1, depth+1.
- POP (post-increment):
  - T1 SEL: outasel=01.
  - T2 ACC: outasel=01, mem_re=1, funsel=10, rsel=001 (SP++), done=1, depth-1.
- LDPC / LDAR / LDSP:
  - T1: funsel=01, arf_i=latched data, rsel=001 / 010 / 100 respectively, done=1.
  - LDSP also sets depth=0.
- CLRALL: T1 funsel=00, rsel=111, depth=0, done=1.
- NOP: T1 done=1, no ARF or memory activity.
- Overflow/underflow:
  - Applies to PUSH with depth==STACK_DEPTH and POP with depth==0.
  - T1: done=1, err=1, rsel=000, no strobes, depth unchanged.
- done and err each last exactly one cycle. The earliest next accept is the cycle after done.
- cmd_valid while busy is ignored and not queued. The requester holds it until cmd_ready.
- 8-bit wrap is left to the ARF; the block does not check SP/PC wrap.
- Reset mid-operation: next edge returns to IDLE with default outputs and depth=0. Partial ARF updates already applied are not undone. ARF contents are not cleared by this reset.
- cmd_valid high during the reset cycle is not accepted.

Test Plan:
- Reset, LDPC 0x40, FETCH → T2 of FETCH: mem_re=1 while OutA=0x40; PC=0x41 afterwards; done at T2.
- LDSP 0x80, PUSH → SP=0x7F after T1; mem_we=1 at T3 with OutA=0x7F; depth=1.
- PUSH then POP → POP T2: mem_re=1 with OutA=0x7F; SP returns to 0x80; depth=0.
- Reset, POP → T1: done=1, err=1, rsel=000, no mem strobes; 17 PUSHes with STACK_DEPTH=16 → the 17th gives err=1 and SP is unchanged.
- LDAR 0x22, then CLRALL → PC=AR=SP=0, depth=0; cmd_valid asserted during busy cycles is not accepted.
- Assert reset during PUSH T2 → next cycle IDLE, cmd_ready=1, mem_we never asserted, SP holds the decremented value, depth=0.
